// File: rtl/uart_rx_pkg.sv
// Shared FSM state type, oversampling constants and baud divisor helper
// for the UART receiver.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam int BAUD_9600   = 32'd9600;
    localparam int BAUD_19200  = 32'd19200;
    localparam int BAUD_57600  = 32'd57600;
    localparam int BAUD_115200 = 32'd115200;

    localparam int OVERSAMPLE = 32'd16;
    localparam int MID_SAMPLE = 32'd7;

    localparam logic [3:0] MID_SAMPLE_CNT  = 4'(MID_SAMPLE);
    localparam logic [3:0] LAST_SAMPLE_CNT = 4'(OVERSAMPLE - 32'd1);

    // Clock cycles per oversampling tick for the selected baud rate
    function automatic logic [15:0] baud_divisor(input int clk_hz, input logic [1:0] sel);
        int baud;
        case (sel)
            2'b00:   baud = BAUD_9600;
            2'b01:   baud = BAUD_19200;
            2'b10:   baud = BAUD_57600;
            2'b11:   baud = BAUD_115200;
            default: baud = BAUD_115200;
        endcase
        return 16'(clk_hz / (baud * OVERSAMPLE));
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO for received characters; the head byte
// is presented without a read strobe and reads as 0x00 while empty.
module uart_rx_fifo #(
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [7:0]                 push_data,
    input  logic                       pop,
    output logic [7:0]                 head_data,
    output logic                       valid,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [AW:0]   count_nxt_s;
    logic          valid_r;
    logic          full_s;
    logic          pop_s;
    logic          wr_s;

    assign full_s = (count_r == DEPTH_CNT);
    assign pop_s  = pop & valid_r;
    // A push into a full FIFO is only accepted when a pop frees a slot in the same cycle
    assign wr_s   = push & (~full_s | pop_s);

    // Occupancy after this cycle's accepted push/pop
    always_comb begin
        count_nxt_s = count_r;
        if (wr_s && !pop_s) begin
            count_nxt_s = count_r + CNT_ONE;
        end else if (!wr_s && pop_s) begin
            count_nxt_s = count_r - CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Storage array
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, occupancy and registered valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            valid_r  <= 1'b0;
        end else begin
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
            valid_r <= (count_nxt_s != '0);
        end
    end

    assign head_data = valid_r ? mem_r[rd_ptr_r] : 8'h00;
    assign valid     = valid_r;
    assign full      = full_s;
    assign level     = count_r;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: synchronizer, 16x oversampling tick generator, frame FSM and
// receive FIFO. Define UART_RX_PARITY_EN for 11-bit frames with even parity.
module uart_receiver
    import uart_rx_pkg::*;
#(
    parameter int CLOCK_FREQ_HZ = 50_000_000,
    parameter int FIFO_DEPTH    = 64
) (
    input  logic                          clock_i,
    input  logic                          reset_n_i,
    input  logic                          uart_rx_i,
    input  logic [1:0]                    baudrate_select_i,
    input  logic                          data_read_i,
    input  logic                          error_clear_i,
    output logic [7:0]                    data_o,
    output logic                          data_valid_o,
    output logic [$clog2(FIFO_DEPTH):0]   data_level_o,
    output logic                          frame_error_o,
    output logic                          overrun_error_o,
    output logic                          parity_error_o
);

`ifdef UART_RX_PARITY_EN
    localparam rx_state_e AFTER_DATA = PARITY;
`else
    localparam rx_state_e AFTER_DATA = STOP;
`endif

    logic        rx_meta_r;
    logic        rx_sync_r;
    logic        rx_prev_r;
    logic        rx_s;
    logic [1:0]  baud_sel_r;
    logic [15:0] divisor_s;
    logic [15:0] tick_cnt_r;
    logic        tick_s;

    rx_state_e   state_r;
    rx_state_e   state_nxt_s;
    logic [3:0]  sample_cnt_r;
    logic [3:0]  sample_nxt_s;
    logic [2:0]  bit_cnt_r;
    logic [2:0]  bit_nxt_s;
    logic [7:0]  shift_r;
    logic [7:0]  shift_nxt_s;
    logic        push_r;
    logic        push_nxt_s;
    logic [7:0]  push_data_r;
    logic        start_det_s;
    logic        frame_set_s;
    logic        overrun_set_s;
    logic        frame_err_r;
    logic        overrun_err_r;
    logic        fifo_full_s;
    logic        fifo_valid_s;
`ifdef UART_RX_PARITY_EN
    logic        parity_set_s;
    logic        parity_err_r;
`endif

    assign rx_s = rx_sync_r;

    // Two-flop synchronizer plus one history flop for falling-edge detection
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= uart_rx_i;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Baud select is only taken between frames so a frame never changes rate
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            baud_sel_r <= 2'b00;
        end else if (state_r == IDLE) begin
            baud_sel_r <= baudrate_select_i;
        end
    end

    assign divisor_s = baud_divisor(CLOCK_FREQ_HZ, baud_sel_r);
    // >= lets the counter recover at once when a faster rate is latched
    assign tick_s    = (tick_cnt_r >= (divisor_s - 16'd1));

    // Oversampling tick counter, phase-aligned to the start edge
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            tick_cnt_r <= 16'd0;
        end else if (start_det_s || tick_s) begin
            tick_cnt_r <= 16'd0;
        end else begin
            tick_cnt_r <= tick_cnt_r + 16'd1;
        end
    end

    // Frame decoder next-state logic
    always_comb begin
        state_nxt_s  = state_r;
        sample_nxt_s = sample_cnt_r;
        bit_nxt_s    = bit_cnt_r;
        shift_nxt_s  = shift_r;
        push_nxt_s   = 1'b0;
        start_det_s  = 1'b0;
        frame_set_s  = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_set_s = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                sample_nxt_s = 4'd0;
                if (rx_prev_r && !rx_s) begin
                    start_det_s = 1'b1;
                    state_nxt_s = START;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                if (tick_s && (sample_cnt_r == MID_SAMPLE_CNT)) begin
                    sample_nxt_s = 4'd0;
                    bit_nxt_s    = 3'd0;
                    state_nxt_s  = rx_s ? IDLE : DATA;
                end else if (tick_s) begin
                    sample_nxt_s = sample_cnt_r + 4'd1;
                end else begin
                    sample_nxt_s = sample_cnt_r;
                end
            end
            DATA: begin
                if (tick_s && (sample_cnt_r == LAST_SAMPLE_CNT)) begin
                    sample_nxt_s = 4'd0;
                    shift_nxt_s  = {rx_s, shift_r[7:1]};
                    if (bit_cnt_r == 3'd7) begin
                        state_nxt_s = AFTER_DATA;
                    end else begin
                        bit_nxt_s = bit_cnt_r + 3'd1;
                    end
                end else if (tick_s) begin
                    sample_nxt_s = sample_cnt_r + 4'd1;
                end else begin
                    sample_nxt_s = sample_cnt_r;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick_s && (sample_cnt_r == LAST_SAMPLE_CNT)) begin
                    sample_nxt_s = 4'd0;
                    parity_set_s = (rx_s != (^shift_r));
                    state_nxt_s  = STOP;
                end else if (tick_s) begin
                    sample_nxt_s = sample_cnt_r + 4'd1;
                end else begin
                    sample_nxt_s = sample_cnt_r;
                end
            end
`endif
            STOP: begin
                if (tick_s && (sample_cnt_r == LAST_SAMPLE_CNT)) begin
                    sample_nxt_s = 4'd0;
                    state_nxt_s  = IDLE;
                    if (rx_s) begin
                        push_nxt_s = 1'b1;
                    end else begin
                        frame_set_s = 1'b1;
                    end
                end else if (tick_s) begin
                    sample_nxt_s = sample_cnt_r + 4'd1;
                end else begin
                    sample_nxt_s = sample_cnt_r;
                end
            end
            default: begin
                state_nxt_s  = IDLE;
                sample_nxt_s = 4'd0;
            end
        endcase
    end

    // Frame decoder state and datapath registers
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_r      <= IDLE;
            sample_cnt_r <= 4'd0;
            bit_cnt_r    <= 3'd0;
            shift_r      <= 8'h00;
            push_r       <= 1'b0;
            push_data_r  <= 8'h00;
        end else begin
            state_r      <= state_nxt_s;
            sample_cnt_r <= sample_nxt_s;
            bit_cnt_r    <= bit_nxt_s;
            shift_r      <= shift_nxt_s;
            push_r       <= push_nxt_s;
            push_data_r  <= shift_r;
        end
    end

    uart_rx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clock_i),
        .rst_n     (reset_n_i),
        .push      (push_r),
        .push_data (push_data_r),
        .pop       (data_read_i),
        .head_data (data_o),
        .valid     (fifo_valid_s),
        .full      (fifo_full_s),
        .level     (data_level_o)
    );

    assign data_valid_o  = fifo_valid_s;
    assign overrun_set_s = push_r & fifo_full_s & ~(data_read_i & fifo_valid_s);

    // Sticky error flags; a new error in the clear cycle keeps the flag set
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            frame_err_r   <= 1'b0;
            overrun_err_r <= 1'b0;
        end else begin
            if (frame_set_s) begin
                frame_err_r <= 1'b1;
            end else if (error_clear_i) begin
                frame_err_r <= 1'b0;
            end
            if (overrun_set_s) begin
                overrun_err_r <= 1'b1;
            end else if (error_clear_i) begin
                overrun_err_r <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Sticky parity flag
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            parity_err_r <= 1'b0;
        end else if (parity_set_s) begin
            parity_err_r <= 1'b1;
        end else if (error_clear_i) begin
            parity_err_r <= 1'b0;
        end
    end
    assign parity_error_o = parity_err_r;
`else
    assign parity_error_o = 1'b0;
`endif

    assign frame_error_o   = frame_err_r;
    assign overrun_error_o = overrun_err_r;

endmodule
